// File: rtl/raw_hazard_ctrl_pkg.sv
// Shared pipeline types for register read-after-write hazard tracking.
// Tags carry a destination index plus a valid bit; x0 is never tracked.
package raw_hazard_ctrl_pkg;

  localparam int NUM_REGS = 32;
  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } rd_tag_t;

endpackage

// File: rtl/raw_hazard_ctrl_if.sv
// ID-stage hazard interface: instruction operands in, stall/busy/WB tag status out.
// master drives the ID-side fields; slave is the hazard controller.
interface raw_hazard_ctrl_if;
  import raw_hazard_ctrl_pkg::*;

  logic                id_valid_i;
  logic [4:0]          id_rs1_addr_i;
  logic                id_rs1_used_i;
  logic [4:0]          id_rs2_addr_i;
  logic                id_rs2_used_i;
  logic [4:0]          id_rd_addr_i;
  logic                id_rd_wren_i;
  logic                flush_i;
  logic                hold_i;
  logic                stall_o;
  logic [NUM_REGS-1:0] busy_o;
  logic [4:0]          wb_rd_addr_o;
  logic                wb_rd_wren_o;
  logic [31:0]         stall_cnt_o;

  modport master (
    output id_valid_i, id_rs1_addr_i, id_rs1_used_i, id_rs2_addr_i, id_rs2_used_i,
    output id_rd_addr_i, id_rd_wren_i, flush_i, hold_i,
    input  stall_o, busy_o, wb_rd_addr_o, wb_rd_wren_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs1_addr_i, id_rs1_used_i, id_rs2_addr_i, id_rs2_used_i,
    input  id_rd_addr_i, id_rd_wren_i, flush_i, hold_i,
    output stall_o, busy_o, wb_rd_addr_o, wb_rd_wren_o, stall_cnt_o
  );

endinterface

// File: rtl/raw_tag_match.sv
// Compares one source register against all in-flight destination tags.
// Purely combinational; slots outside cmp_mask never produce a hit.
module raw_tag_match
  import raw_hazard_ctrl_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic [4:0]               src_addr,
  input  logic                     src_used,
  input  rd_tag_t [STAGES-1:0]     tags,
  input  logic [STAGES-1:0]        cmp_mask,
  output logic                     hit
);

  logic [STAGES-1:0] slot_hit;

  always_comb begin
    slot_hit = '0;
    for (int k = 0; k < STAGES; k++) begin
      slot_hit[k] = cmp_mask[k] & tags[k].valid & (tags[k].rd == src_addr);
    end
  end

  assign hit = src_used & (src_addr != REG_X0) & (|slot_hit);

endmodule

// File: rtl/raw_hazard_ctrl.sv
// RAW hazard controller: shadow pipeline of rd tags from EX to WB; stalls ID on a match.
// stall_o is combinational from ID operands and current tags; hold_i freezes tags and the counter.
module raw_hazard_ctrl
  import raw_hazard_ctrl_pkg::*;
#(
  parameter int STAGES         = 3,
  parameter int WB_WRITE_FIRST = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  raw_hazard_ctrl_if.slave   hz
);

  localparam logic [STAGES-1:0] ALL_MASK = '1;
  // A write-first register file already returns the WB value, so the WB slot is masked off.
  localparam logic [STAGES-1:0] CMP_MASK = (WB_WRITE_FIRST != 0) ? (ALL_MASK >> 1) : ALL_MASK;

  rd_tag_t [STAGES-1:0] slot_q;
  rd_tag_t              new_tag;
  logic                 hit_rs1;
  logic                 hit_rs2;
  logic                 stall;
  logic                 issue;
  logic [NUM_REGS-1:0]  busy;
  logic [31:0]          stall_cnt_q;

  raw_tag_match #(.STAGES(STAGES)) u_match_rs1 (
    .src_addr (hz.id_rs1_addr_i),
    .src_used (hz.id_rs1_used_i),
    .tags     (slot_q),
    .cmp_mask (CMP_MASK),
    .hit      (hit_rs1)
  );

  raw_tag_match #(.STAGES(STAGES)) u_match_rs2 (
    .src_addr (hz.id_rs2_addr_i),
    .src_used (hz.id_rs2_used_i),
    .tags     (slot_q),
    .cmp_mask (CMP_MASK),
    .hit      (hit_rs2)
  );

  // Flush beats stall: the instruction in ID is being discarded anyway.
  assign stall = hz.id_valid_i & (hit_rs1 | hit_rs2) & ~hz.flush_i;
  assign issue = hz.id_valid_i & ~stall & ~hz.flush_i;

  always_comb begin
    new_tag = '0;
    if (issue && hz.id_rd_wren_i && (hz.id_rd_addr_i != REG_X0)) begin
      new_tag.valid = 1'b1;
      new_tag.rd    = hz.id_rd_addr_i;
    end
  end

  always_comb begin
    busy = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (slot_q[k].valid) begin
        busy[slot_q[k].rd] = 1'b1;
      end
    end
    busy[REG_X0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      slot_q      <= '0;
      stall_cnt_q <= '0;
    end else if (!hz.hold_i) begin
      for (int k = STAGES - 1; k > 0; k--) begin
        slot_q[k] <= slot_q[k-1];
      end
      slot_q[0] <= new_tag;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign hz.stall_o      = stall;
  assign hz.busy_o       = busy;
  assign hz.wb_rd_addr_o = slot_q[STAGES-1].rd;
  assign hz.wb_rd_wren_o = slot_q[STAGES-1].valid;
  assign hz.stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_raw_hazard_ctrl.sv
// Bench for raw_hazard_ctrl: two instances (WB compared / WB write-first) share one stimulus.
// Expected outputs are queued at drive time and compared mid-cycle against the DUTs.
module tb_raw_hazard_ctrl;
  import raw_hazard_ctrl_pkg::*;

  localparam int S = 3;

  typedef struct packed {
    logic        stall;
    logic [31:0] busy;
    logic        wren;
    logic [4:0]  wba;
    logic [31:0] cnt;
  } exp_t;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic rst_ni;

  logic       id_valid, rs1_used, rs2_used, rd_wren, flush, hold;
  logic [4:0] rs1, rs2, rd;

  raw_hazard_ctrl_if hif0();
  raw_hazard_ctrl_if hif1();

  assign hif0.id_valid_i = id_valid;   assign hif1.id_valid_i = id_valid;
  assign hif0.id_rs1_addr_i = rs1;     assign hif1.id_rs1_addr_i = rs1;
  assign hif0.id_rs1_used_i = rs1_used; assign hif1.id_rs1_used_i = rs1_used;
  assign hif0.id_rs2_addr_i = rs2;     assign hif1.id_rs2_addr_i = rs2;
  assign hif0.id_rs2_used_i = rs2_used; assign hif1.id_rs2_used_i = rs2_used;
  assign hif0.id_rd_addr_i = rd;       assign hif1.id_rd_addr_i = rd;
  assign hif0.id_rd_wren_i = rd_wren;  assign hif1.id_rd_wren_i = rd_wren;
  assign hif0.flush_i = flush;         assign hif1.flush_i = flush;
  assign hif0.hold_i = hold;           assign hif1.hold_i = hold;

  raw_hazard_ctrl #(.STAGES(S), .WB_WRITE_FIRST(0)) dut0 (.clk_i(clk_i), .rst_ni(rst_ni), .hz(hif0));
  raw_hazard_ctrl #(.STAGES(S), .WB_WRITE_FIRST(1)) dut1 (.clk_i(clk_i), .rst_ni(rst_ni), .hz(hif1));

  int vectors = 0;
  int miscompares = 0;

  // Reference state: entry k is the tag issued k advancing edges ago (rd=0 means bubble).
  logic        mv [2][S];
  logic [4:0]  mr [2][S];
  logic [31:0] mc [2];

  exp_t sb0[$];
  exp_t sb1[$];
  logic        obs_stall [2];
  logic [31:0] obs_busy0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_exp(input int d);
    exp_t e;
    int   lim;
    logic h1, h2;
    lim = (d == 1) ? S - 1 : S;
    h1 = 1'b0;
    h2 = 1'b0;
    e = '0;
    for (int k = 0; k < S; k++) begin
      if (mv[d][k]) begin
        e.busy[mr[d][k]] = 1'b1;
        if (k < lim && rs1_used && rs1 != 5'd0 && mr[d][k] == rs1) h1 = 1'b1;
        if (k < lim && rs2_used && rs2 != 5'd0 && mr[d][k] == rs2) h2 = 1'b1;
      end
    end
    e.stall = id_valid && (h1 || h2) && !flush;
    e.wren  = mv[d][S-1];
    e.wba   = mr[d][S-1];
    e.cnt   = mc[d];
    return e;
  endfunction

  task automatic model_step(input int d);
    exp_t e;
    logic iss;
    e = model_exp(d);
    if (!rst_ni) begin
      for (int k = 0; k < S; k++) begin mv[d][k] = 1'b0; mr[d][k] = 5'd0; end
      mc[d] = 32'd0;
    end else if (!hold) begin
      for (int k = S - 1; k > 0; k--) begin mv[d][k] = mv[d][k-1]; mr[d][k] = mr[d][k-1]; end
      iss = id_valid && !e.stall && !flush && rd_wren && rd != 5'd0;
      mv[d][0] = iss;
      mr[d][0] = iss ? rd : 5'd0;
      if (e.stall && mc[d] != 32'hFFFF_FFFF) mc[d] = mc[d] + 32'd1;
    end
  endtask

  task automatic cmp_one(input string who, input exp_t a, input exp_t e);
    chk({who, ".stall"}, {31'd0, a.stall}, {31'd0, e.stall});
    chk({who, ".busy"},  a.busy, e.busy);
    chk({who, ".wren"},  {31'd0, a.wren}, {31'd0, e.wren});
    chk({who, ".wba"},   {27'd0, a.wba}, {27'd0, e.wba});
    chk({who, ".cnt"},   a.cnt, e.cnt);
  endtask

  // One cycle: queue expectations, compare on the falling edge, advance the model on the rising edge.
  task automatic tick();
    exp_t a0, a1;
    sb0.push_back(model_exp(0));
    sb1.push_back(model_exp(1));
    @(negedge clk_i);
    a0 = {hif0.stall_o, hif0.busy_o, hif0.wb_rd_wren_o, hif0.wb_rd_addr_o, hif0.stall_cnt_o};
    a1 = {hif1.stall_o, hif1.busy_o, hif1.wb_rd_wren_o, hif1.wb_rd_addr_o, hif1.stall_cnt_o};
    obs_stall[0] = a0.stall;
    obs_stall[1] = a1.stall;
    obs_busy0    = a0.busy;
    cmp_one("d0", a0, sb0.pop_front());
    cmp_one("d1", a1, sb1.pop_front());
    @(posedge clk_i);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [4:0] r1, input logic u1,
                           input logic [4:0] r2, input logic u2, input logic [4:0] d, input logic w);
    id_valid = v; rs1 = r1; rs1_used = u1; rs2 = r2; rs2_used = u2; rd = d; rd_wren = w;
    flush = 1'b0; hold = 1'b0;
  endtask

  task automatic idle();
    set_instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    for (int i = 0; i < 2; i++) begin
      id_valid = 1'($urandom); rs1 = 5'($urandom); rs1_used = 1'($urandom);
      rs2 = 5'($urandom); rs2_used = 1'($urandom); rd = 5'($urandom);
      rd_wren = 1'($urandom); flush = 1'($urandom); hold = 1'($urandom);
      @(posedge clk_i);
      model_step(0);
      model_step(1);
      #1;
    end
    idle();
    rst_ni = 1'b1;
  endtask

  initial begin
    int ns0, ns1;
    idle();
    rst_ni = 1'b0;

    // Reset with random inputs
    do_reset();
    chk("rst.stall0", {31'd0, hif0.stall_o}, 32'd0);
    chk("rst.busy0",  hif0.busy_o, 32'd0);
    chk("rst.cnt0",   hif0.stall_cnt_o, 32'd0);
    chk("rst.wren0",  {31'd0, hif0.wb_rd_wren_o}, 32'd0);
    chk("rst.wren1",  {31'd0, hif1.wb_rd_wren_o}, 32'd0);
    tick();

    // Back-to-back RAW: addi x5 then add x6,x5,x1
    do_reset();
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    tick();
    set_instr(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1);
    ns0 = 0; ns1 = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      ns0 += int'(obs_stall[0]);
      ns1 += int'(obs_stall[1]);
      if (i < 3) chk("b2b.busy5", {31'd0, obs_busy0[5]}, 32'd1);
    end
    chk("b2b.issue4", {31'd0, hif0.busy_o[6]}, 32'd1);
    idle();
    tick();
    chk("b2b.nstall0", ns0, 3);
    chk("b2b.nstall1", ns1, 2);
    chk("b2b.cnt0", hif0.stall_cnt_o, 32'd3);
    chk("b2b.cnt1", hif1.stall_cnt_o, 32'd2);

    // x0 writes and unused operands never stall
    do_reset();
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    tick();
    set_instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1);
    tick();
    chk("x0.stall0", {31'd0, obs_stall[0]}, 32'd0);
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    tick();
    set_instr(1'b1, 5'd7, 1'b0, 5'd7, 1'b0, 5'd8, 1'b1);
    tick();
    chk("unused.stall0", {31'd0, obs_stall[0]}, 32'd0);
    chk("unused.stall1", {31'd0, obs_stall[1]}, 32'd0);

    // Flush during a hazard
    do_reset();
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    tick();
    set_instr(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1);
    flush = 1'b1;
    tick();
    chk("flush.stall0", {31'd0, obs_stall[0]}, 32'd0);
    chk("flush.stall1", {31'd0, obs_stall[1]}, 32'd0);
    idle();
    tick();
    chk("flush.busy10", {31'd0, obs_busy0[10]}, 32'd0);
    chk("flush.busy9",  {31'd0, obs_busy0[9]}, 32'd1);

    // Hold freezes tags and counter while the stall persists
    do_reset();
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
    tick();
    set_instr(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1);
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold.stall0", {31'd0, obs_stall[0]}, 32'd1);
      chk("hold.stall1", {31'd0, obs_stall[1]}, 32'd1);
    end
    chk("hold.cnt0", hif0.stall_cnt_o, 32'd0);
    chk("hold.cnt1", hif1.stall_cnt_o, 32'd0);
    hold = 1'b0;
    ns0 = 0; ns1 = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      ns0 += int'(obs_stall[0]);
      ns1 += int'(obs_stall[1]);
    end
    idle();
    tick();
    chk("hold.nstall0", ns0, 3);
    chk("hold.nstall1", ns1, 2);
    chk("hold.cnt0end", hif0.stall_cnt_o, 32'd3);
    chk("hold.cnt1end", hif1.stall_cnt_o, 32'd2);

    // Random traffic over a small register range, with occasional flush/hold/reset
    for (int i = 0; i < 400; i++) begin
      rst_ni   = ($urandom_range(0, 49) != 0);
      id_valid = ($urandom_range(0, 3) != 0);
      rs1 = 5'($urandom_range(0, 7)); rs1_used = 1'($urandom);
      rs2 = 5'($urandom_range(0, 7)); rs2_used = 1'($urandom);
      rd  = 5'($urandom_range(0, 7)); rd_wren  = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 7) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst_ni = 1'b1;
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
